// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - condition codes, NZCV layout and condition evaluation
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] nzcv_t;

    // NV and anything unexpected evaluate to 0 so the result is never X
    function automatic logic cond_eval(input cond_e c, input nzcv_t f);
        logic n, z, cf, v, r;
        n  = f[FLAG_N];
        z  = f[FLAG_Z];
        cf = f[FLAG_C];
        v  = f[FLAG_V];
        case (c)
            EQ:      r = z;
            NE:      r = ~z;
            CS:      r = cf;
            CC:      r = ~cf;
            MI:      r = n;
            PL:      r = ~n;
            VS:      r = v;
            VC:      r = ~v;
            HI:      r = cf & ~z;
            LS:      r = ~(cf & ~z);
            GE:      r = (n == v);
            LT:      r = (n != v);
            GT:      r = ~z & (n == v);
            LE:      r = ~(~z & (n == v));
            AL:      r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/flag_ctx_reg.sv
// rtl/flag_ctx_reg.sv - per-context NZCV flag storage with split NZ/CV write enables
module flag_ctx_reg
    import cond_pkg::*;
#(
    parameter int NCTX  = 2,
    parameter int CTX_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_nz,
    input  logic             we_cv,
    input  logic [CTX_W-1:0] wr_ctx,
    input  logic [1:0]       wr_nz,
    input  logic [1:0]       wr_cv,
    input  logic [CTX_W-1:0] rd_ctx,
    output nzcv_t            rd_flags
);

    nzcv_t flags [NCTX];

    // Flag array: reset clears every context; NZ and CV halves written independently
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCTX; i++) begin
            if (reset) begin
                flags[i] <= '0;
            end else if (wr_ctx == CTX_W'(i)) begin
                if (we_nz) flags[i][FLAG_N:FLAG_Z] <= wr_nz;
                if (we_cv) flags[i][FLAG_C:FLAG_V] <= wr_cv;
            end
        end
    end

    // Read port: a select beyond the populated contexts reads as zero
    always_comb begin
        rd_flags = '0;
        for (int i = 0; i < NCTX; i++) begin
            if (rd_ctx == CTX_W'(i)) rd_flags = flags[i];
        end
    end

endmodule

// File: rtl/cond_exec_unit.sv
// rtl/cond_exec_unit.sv - multi-context ARM condition-execution stage with optional output register
module cond_exec_unit
    import cond_pkg::*;
#(
    parameter  int NCTX  = 2,
    parameter  int PIPE  = 1,
    localparam int CTX_W = (NCTX > 1) ? $clog2(NCTX) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [CTX_W-1:0] ctx,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_w,
    input  logic             pcs,
    input  logic             reg_w,
    input  logic             mem_w,
    input  logic             no_write,
    output logic             out_valid,
    output logic             cond_ex_o,
    output logic             pcs_o,
    output logic             reg_w_o,
    output logic             mem_w_o,
    output logic             undef_o,
    output logic [3:0]       flags_o
);

    // One extra bit so NCTX itself is representable when it is a power of two
    localparam logic [CTX_W:0] NCTX_V = (CTX_W+1)'(NCTX);

    nzcv_t cur_flags;
    logic  ctx_ok;
    logic  cond_pass;
    logic  wr_en;
    logic  cex_c, pcs_c, reg_w_c, mem_w_c, undef_c;

    flag_ctx_reg #(
        .NCTX  (NCTX),
        .CTX_W (CTX_W)
    ) u_flags (
        .clk      (clk),
        .reset    (reset),
        .we_nz    (wr_en & flag_w[1]),
        .we_cv    (wr_en & flag_w[0]),
        .wr_ctx   (ctx),
        .wr_nz    (alu_flags[FLAG_N:FLAG_Z]),
        .wr_cv    (alu_flags[FLAG_C:FLAG_V]),
        .rd_ctx   (ctx),
        .rd_flags (cur_flags)
    );

    // Evaluate against stored flags and form the gated controls for this instruction
    always_comb begin
        ctx_ok    = ({1'b0, ctx} < NCTX_V);
        cond_pass = ctx_ok & cond_eval(cond_e'(cond), cur_flags);
        cex_c     = in_valid & cond_pass;
        pcs_c     = cex_c & pcs;
        reg_w_c   = cex_c & reg_w & ~no_write;
        mem_w_c   = cex_c & mem_w;
        undef_c   = in_valid & ((cond == 4'b1111) | ~ctx_ok);
        wr_en     = cex_c & ~stall & ~flush;
    end

    assign flags_o = cur_flags;

    if (PIPE != 0) begin : g_pipe
        // Output register: reset beats flush beats stall beats load
        always_ff @(posedge clk) begin
            if (reset || flush) begin
                out_valid <= 1'b0;
                cond_ex_o <= 1'b0;
                pcs_o     <= 1'b0;
                reg_w_o   <= 1'b0;
                mem_w_o   <= 1'b0;
                undef_o   <= 1'b0;
            end else if (!stall) begin
                out_valid <= in_valid;
                cond_ex_o <= cex_c;
                pcs_o     <= pcs_c;
                reg_w_o   <= reg_w_c;
                mem_w_o   <= mem_w_c;
                undef_o   <= undef_c;
            end
        end
    end else begin : g_comb
        logic ov;
        // Combinational outputs, all forced low when the slot is stalled or killed
        always_comb begin
            ov        = in_valid & ~stall & ~flush;
            out_valid = ov;
            cond_ex_o = cex_c & ov;
            pcs_o     = pcs_c & ov;
            reg_w_o   = reg_w_c & ov;
            mem_w_o   = mem_w_c & ov;
            undef_o   = undef_c & ov;
        end
    end

endmodule

// File: tb/tb_cond_exec_unit.sv
// tb/tb_cond_exec_unit.sv - directed self-checking bench for cond_exec_unit
module tb_cond_exec_unit;

    logic       clk = 1'b0;
    logic       reset, in_valid, stall, flush;
    logic [0:0] ctx_a;
    logic [1:0] ctx_b;
    logic [3:0] cond, alu_flags;
    logic [1:0] flag_w;
    logic       pcs, reg_w, mem_w, no_write;

    logic       a_ov, a_cex, a_pcs, a_rw, a_mw, a_und;
    logic [3:0] a_flags;
    logic       b_ov, b_cex, b_pcs, b_rw, b_mw, b_und;
    logic [3:0] b_flags;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cond_exec_unit #(.NCTX(2), .PIPE(0)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .ctx(ctx_a), .cond(cond), .alu_flags(alu_flags), .flag_w(flag_w),
        .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .no_write(no_write),
        .out_valid(a_ov), .cond_ex_o(a_cex), .pcs_o(a_pcs), .reg_w_o(a_rw),
        .mem_w_o(a_mw), .undef_o(a_und), .flags_o(a_flags)
    );

    cond_exec_unit #(.NCTX(3), .PIPE(1)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .ctx(ctx_b), .cond(cond), .alu_flags(alu_flags), .flag_w(flag_w),
        .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .no_write(no_write),
        .out_valid(b_ov), .cond_ex_o(b_cex), .pcs_o(b_pcs), .reg_w_o(b_rw),
        .mem_w_o(b_mw), .undef_o(b_und), .flags_o(b_flags)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctx(input logic [1:0] c);
        ctx_b = c;
        ctx_a = c[0];
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        set_ctx(2'd0); cond = 4'h0; alu_flags = 4'h0; flag_w = 2'b00;
        pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0; no_write = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_a_flags", a_flags, 4'b0000);
        chk("rst_b_flags", b_flags, 4'b0000);
        chk("rst_b_ov", b_ov, 1'b0);
        chk("rst_b_cex", b_cex, 1'b0);
        chk("rst_b_und", b_und, 1'b0);

        in_valid = 1'b1; pcs = 1'b1; reg_w = 1'b1; mem_w = 1'b1; cond = 4'h0;
        #1;
        chk("eq_zero_cex", a_cex, 1'b0);
        chk("eq_zero_pcs", a_pcs, 1'b0);
        cond = 4'h1;
        #1;
        chk("ne_zero_cex", a_cex, 1'b1);
        chk("ne_zero_pcs", a_pcs, 1'b1);
        chk("ne_zero_rw", a_rw, 1'b1);
        chk("ne_zero_ov", a_ov, 1'b1);

        cond = 4'hE; flag_w = 2'b11; alu_flags = 4'b0100;
        tick();
        chk("al_wr_flags", a_flags, 4'b0100);
        chk("pipe_al_ov", b_ov, 1'b1);
        chk("pipe_al_cex", b_cex, 1'b1);
        chk("pipe_al_pcs", b_pcs, 1'b1);
        flag_w = 2'b00; cond = 4'h0;
        #1;
        chk("eq_ctx0_cex", a_cex, 1'b1);
        set_ctx(2'd1);
        #1;
        chk("eq_ctx1_cex", a_cex, 1'b0);
        chk("ctx1_flags", a_flags, 4'b0000);

        cond = 4'hE; flag_w = 2'b11; alu_flags = 4'b1000;
        tick();
        chk("ctx1_nzcv_wr", a_flags, 4'b1000);
        flag_w = 2'b01; alu_flags = 4'b0011;
        tick();
        chk("ctx1_cv_wr", a_flags, 4'b1011);
        chk("ctx1_cv_wr_b", b_flags, 4'b1011);
        flag_w = 2'b00;
        cond = 4'hA; #1; chk("ge_1011", a_cex, 1'b1);
        cond = 4'h6; #1; chk("vs_1011", a_cex, 1'b1);
        cond = 4'hB; #1; chk("lt_1011", a_cex, 1'b0);
        cond = 4'h8; #1; chk("hi_1011", a_cex, 1'b1);
        cond = 4'h9; #1; chk("ls_1011", a_cex, 1'b0);
        cond = 4'hD; #1; chk("le_1011", a_cex, 1'b0);

        cond = 4'h0; flag_w = 2'b11; alu_flags = 4'b1111;
        #1;
        chk("fail_cex", a_cex, 1'b0);
        chk("fail_rw", a_rw, 1'b0);
        chk("fail_mw", a_mw, 1'b0);
        tick();
        chk("fail_no_flag_wr", a_flags, 4'b1011);
        flag_w = 2'b00; cond = 4'hE; no_write = 1'b1;
        #1;
        chk("nowrite_rw", a_rw, 1'b0);
        chk("nowrite_mw", a_mw, 1'b1);
        no_write = 1'b0;

        set_ctx(2'd0); cond = 4'h1;
        tick();
        chk("pre_stall_ov", b_ov, 1'b1);
        chk("pre_stall_cex", b_cex, 1'b0);
        cond = 4'h0; flag_w = 2'b11; alu_flags = 4'b0000; stall = 1'b1;
        #1;
        chk("stall_comb_ov", a_ov, 1'b0);
        tick();
        chk("stall1_ov", b_ov, 1'b1);
        chk("stall1_cex", b_cex, 1'b0);
        chk("stall1_flags", b_flags, 4'b0100);
        tick();
        chk("stall2_cex", b_cex, 1'b0);
        chk("stall2_pcs", b_pcs, 1'b0);
        chk("stall2_flags", b_flags, 4'b0100);
        flush = 1'b1;
        tick();
        chk("flush_ov", b_ov, 1'b0);
        chk("flush_pcs", b_pcs, 1'b0);
        chk("flush_flags", b_flags, 4'b0100);
        flush = 1'b0; stall = 1'b0; flag_w = 2'b00;
        tick();
        chk("resume_ov", b_ov, 1'b1);
        chk("resume_cex", b_cex, 1'b1);
        chk("resume_pcs", b_pcs, 1'b1);

        cond = 4'hF;
        #1;
        chk("nv_a_und", a_und, 1'b1);
        chk("nv_a_cex", a_cex, 1'b0);
        tick();
        chk("nv_b_und", b_und, 1'b1);
        chk("nv_b_cex", b_cex, 1'b0);
        cond = 4'hE; flag_w = 2'b11; alu_flags = 4'b1111; ctx_b = 2'd3; ctx_a = 1'b1;
        tick();
        chk("ctx3_und", b_und, 1'b1);
        chk("ctx3_cex", b_cex, 1'b0);
        in_valid = 1'b0; flag_w = 2'b00;
        ctx_b = 2'd0; #1; chk("ctx3_keep0", b_flags, 4'b0100);
        ctx_b = 2'd1; #1; chk("ctx3_keep1", b_flags, 4'b1011);
        ctx_b = 2'd2; #1; chk("ctx3_keep2", b_flags, 4'b0000);

        in_valid = 1'b1; flag_w = 2'b11; alu_flags = 4'b1111; cond = 4'hE;
        tick();
        chk("burst_ctx2", b_flags, 4'b1111);
        reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0; flag_w = 2'b00;
        #1;
        chk("mid_rst_ov", b_ov, 1'b0);
        chk("mid_rst_cex", b_cex, 1'b0);
        ctx_b = 2'd2; #1; chk("mid_rst_f2", b_flags, 4'b0000);
        ctx_b = 2'd1; #1; chk("mid_rst_f1", b_flags, 4'b0000);
        ctx_b = 2'd0; #1; chk("mid_rst_f0", b_flags, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
